// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Bits needed for a step counter that can hold the value n.
  function automatic int unsigned step_cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_data_path.sv
// Restoring-division datapath: R/Q/D registers, ripple subtractor and restore mux.
module div_data_path
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] q_next,
  output logic [N-1:0] rem_next
);

  logic [N:0]   r_q, r_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] d_q, d_d;

  logic [N:0]   r_sh;
  logic [N:0]   sub_b;
  logic [N:0]   trial;
  logic [N:0]   r_next;
  logic         borrow;

  // R never exceeds the divisor, so its MSB is always 0 and drops out of the shift.
  always_comb begin
    r_sh  = (r_q << 1) | {{N{1'b0}}, q_q[N-1]};
    sub_b = {1'b0, d_q};
  end

  always_comb begin : ripple_sub
    logic bw;
    bw    = 1'b0;
    trial = '0;
    for (int unsigned i = 0; i <= N; i++) begin
      trial[i] = r_sh[i] ^ sub_b[i] ^ bw;
      bw       = (~r_sh[i] & sub_b[i]) | (~(r_sh[i] ^ sub_b[i]) & bw);
    end
    borrow = bw;
  end

  always_comb begin
    r_next   = borrow ? r_sh : trial;
    q_next   = {q_q[N-2:0], ~borrow};
    rem_next = r_next[N-1:0];
  end

  always_comb begin
    r_d = r_q;
    q_d = q_q;
    d_d = d_q;
    if (load) begin
      r_d = '0;
      q_d = dividend;
      d_d = divisor;
    end else if (step) begin
      r_d = r_next;
      q_d = q_next;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
    end else begin
      r_q <= r_d;
      q_q <= q_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider: FSM, step counter and result registers around div_data_path.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int unsigned CW = step_cnt_width(N);

  div_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] quot_q, quot_d;
  logic [N-1:0] rem_q, rem_d;
  logic         dbz_q, dbz_d;
  logic         armed_q, armed_d;

  logic         dp_load;
  logic         dp_step;
  logic [N-1:0] q_next;
  logic [N-1:0] rem_next;

  div_data_path #(.N(N)) u_data_path (
    .clk      (clk),
    .clr      (clr),
    .load     (dp_load),
    .step     (dp_step),
    .dividend (dividend),
    .divisor  (divisor),
    .q_next   (q_next),
    .rem_next (rem_next)
  );

  // armed_q stays low for the first edge after reset release so a start
  // presented across the release is never accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    armed_d = 1'b1;
    dp_load = 1'b0;
    dp_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && armed_q) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dp_load = 1'b1;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          quot_d  = q_next;
          rem_d   = rem_next;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    quotient    = quot_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (N=4).
module tb_seq_divider;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request from IDLE: accept, N steps (or none for /0), DONE, back to IDLE.
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] exp_q;
    logic [N-1:0] exp_r;
    logic         exp_z;
    exp_z = (b == 0);
    exp_q = exp_z ? 4'hF : a / b;
    exp_r = exp_z ? a : a % b;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 4'($urandom_range(15, 0));
    divisor  = 4'($urandom_range(15, 0));
    check("busy_after_accept", busy, 1);
    if (!exp_z) begin
      check("dbz_cleared_on_accept", div_by_zero, 0);
      for (int k = 0; k < N; k++) begin
        check("done_early", done, 0);
        check("busy_iter", busy, 1);
        tick();
      end
    end
    check("done_high", done, 1);
    check("busy_in_done", busy, 1);
    check("quotient", quotient, exp_q);
    check("remainder", remainder, exp_r);
    check("div_by_zero", div_by_zero, exp_z);
    if (!exp_z) begin
      check("invariant", int'(quotient) * int'(b) + int'(remainder), a);
      check("rem_lt_div", remainder < b, 1);
    end
    tick();
    check("done_pulse_end", done, 0);
    check("busy_fall", busy, 0);
    check("quotient_hold", quotient, exp_q);
    check("remainder_hold", remainder, exp_r);
  endtask

  initial begin
    clr      = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    clr = 1'b1;
    tick();

    run_div(4'd13, 4'd3);
    run_div(4'd15, 4'd1);
    run_div(4'd7, 4'd9);
    run_div(4'd0, 4'd5);
    run_div(4'd9, 4'd0);
    run_div(4'd8, 4'd2);

    // start held high through ITER and DONE with new operands: ignored
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    dividend = 4'd2;
    divisor  = 4'd1;
    repeat (N) tick();
    check("ign_done", done, 1);
    check("ign_quotient", quotient, 4);
    check("ign_remainder", remainder, 1);
    tick();
    check("ign_done_fall", done, 0);
    check("ign_busy_fall", busy, 0);
    start = 1'b0;
    tick();
    check("ign_no_queue", busy, 0);
    check("ign_q_hold", quotient, 4);

    // reset in the middle of an iteration
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_busy", busy, 1);
    clr = 1'b0;
    #1;
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dbz", div_by_zero, 0);
    dividend = 4'd14;
    divisor  = 4'd4;
    start    = 1'b1;
    #2;
    clr = 1'b1;
    tick();
    check("start_at_release_ignored", busy, 0);
    run_div(4'd14, 4'd4);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(4'(a), 4'(b));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
